// File: rtl/writeback_queue_pkg.sv
// writeback_queue_pkg: shared widths, entry layout and enqueue normalisation
package writeback_queue_pkg;
  localparam int IDX_W = 5;
  localparam int DATA_W = 24;
  localparam logic [IDX_W-1:0] FULL_IDX = 5'd28;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } entry_t;
  // Registers below FULL_IDX only hold 16 significant bits; the upper byte is forced to zero.
  function automatic logic [DATA_W-1:0] norm_data(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] d);
    return idx >= FULL_IDX ? d : {{(DATA_W-16){1'b0}}, d[15:0]};
  endfunction
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: youngest occupied queue entry matching one read index
module wb_fwd_match import writeback_queue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int PW = 2
) (
  input  entry_t [DEPTH-1:0] entries_i,
  input  logic [PW-1:0]      rd_ptr_i,
  input  logic [2:0]         count_i,
  input  logic [IDX_W-1:0]   index_i,
  output logic               hit_o,
  output logic [DATA_W-1:0]  data_o
);
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit_o = 1'b0;
    data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k < int'(count_i) && entries_i[PW'(rd_ptr_i + PW'(k))].idx == index_i) begin
        hit_o = 1'b1;
        data_o = entries_i[PW'(rd_ptr_i + PW'(k))].data;
      end
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: FIFO of pending register writes with decode-stage forwarding
module writeback_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = writeback_queue_pkg::IDX_W,
  parameter int DATA_W = writeback_queue_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [IDX_W-1:0]  alu_index,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [IDX_W-1:0]  ld_index,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic [IDX_W-1:0]  write_index,
  output logic [DATA_W-1:0] write_data,
  output logic              WRITE_ENABLE,
  input  logic [IDX_W-1:0]  fwd_index_1,
  input  logic [IDX_W-1:0]  fwd_index_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic [DATA_W-1:0] fwd_data_2,
  output logic [31:0]       pending,
  output logic [2:0]        count
);
  import writeback_queue_pkg::*;
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot;
  logic [2:0] count_q, count_d, free;
  logic ld_push, alu_push;
  assign WRITE_ENABLE = count_q != 3'd0;
  assign count = count_q;
  assign write_index = WRITE_ENABLE ? mem_q[rd_ptr_q].idx : '0;
  assign write_data = WRITE_ENABLE ? mem_q[rd_ptr_q].data : '0;
  // Acceptance: the head popping this cycle frees its slot; load takes priority when one slot is left.
  always_comb begin
    free = 3'(DEPTH) - count_q + {2'b0, WRITE_ENABLE};
    ld_ready = free != 3'd0;
    alu_ready = free >= 3'd2 || (free == 3'd1 && !ld_valid);
    ld_push = ld_valid && ld_ready;
    alu_push = alu_valid && alu_ready;
    alu_slot = wr_ptr_q + PW'(ld_push);
    rd_ptr_d = rd_ptr_q + PW'(WRITE_ENABLE);
    wr_ptr_d = wr_ptr_q + PW'(ld_push) + PW'(alu_push);
    count_d = count_q - {2'b0, WRITE_ENABLE} + {2'b0, ld_push} + {2'b0, alu_push};
  end
  // Queue bookkeeping; reset empties the queue so stale entries are never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
  end
  // Entry storage; the load goes in first so it is older than a same-cycle ALU result.
  always_ff @(posedge clk) begin
    if (ld_push) mem_q[wr_ptr_q] <= '{idx: ld_index, data: norm_data(ld_index, ld_data)};
    if (alu_push) mem_q[alu_slot] <= '{idx: alu_index, data: norm_data(alu_index, alu_data)};
  end
  // Scoreboard of registers with a write still in flight, rebuilt from occupied entries.
  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++)
      if (k < int'(count_q)) pending[mem_q[PW'(rd_ptr_q + PW'(k))].idx] = 1'b1;
  end
  wb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd_1 (
    .entries_i(mem_q), .rd_ptr_i(rd_ptr_q), .count_i(count_q),
    .index_i(fwd_index_1), .hit_o(fwd_hit_1), .data_o(fwd_data_1)
  );
  wb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd_2 (
    .entries_i(mem_q), .rd_ptr_i(rd_ptr_q), .count_i(count_q),
    .index_i(fwd_index_2), .hit_o(fwd_hit_2), .data_o(fwd_data_2)
  );
endmodule
